// File: rtl/fp_double.sv
// IEEE-754 binary64 container used for the estimate vectors.
package fp_double;

   localparam int unsigned DOUBLE_W = 64;

   typedef logic [DOUBLE_W-1:0] double;

endpackage

// File: rtl/fsm_iter.sv
// State encoding for the fixed-point iteration controller.
package fsm_iter;

   typedef enum logic [3:0] {
      IDLE_IT,
      CLEAR_IT,
      LAUNCH_UPD_IT,
      WAIT_UPD_IT,
      LAUNCH_CV_IT,
      WAIT_CV_IT,
      SETTLE_IT,
      DECIDE_IT,
      DONE_IT,
      XXX_IT
   } state_iter;

endpackage

// File: rtl/iteration_controller.sv
// Fixed-point iteration loop: launches the update engine, then the convergence checker,
// and repeats until the checker reports convergence or the iteration cap is reached.
module iteration_controller
   import fp_double::*;
   import fsm_iter::*;
#(
   parameter int unsigned SIZE_N   = 8,
   parameter int unsigned MAX_ITER = 64,
   parameter int unsigned SETTLE   = 1,
   localparam int unsigned IterW   = $clog2(MAX_ITER + 1)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic [SIZE_N-1:0][DOUBLE_W-1:0]  init_vector,
   output logic                             upd_clr,
   output logic                             upd_start,
   output logic [SIZE_N-1:0][DOUBLE_W-1:0]  upd_vector,
   input  logic                             upd_f,
   input  logic [SIZE_N-1:0][DOUBLE_W-1:0]  upd_result,
   output logic                             cv_clr,
   output logic                             cv_start,
   output logic [SIZE_N-1:0][DOUBLE_W-1:0]  cv_vector,
   output logic [SIZE_N-1:0][DOUBLE_W-1:0]  cv_next_vector,
   input  logic                             cv_f,
   input  logic                             cv_converged,
   output logic                             busy,
   output logic                             done,
   output logic                             converged,
   output logic [IterW-1:0]                 iterations,
   output logic [SIZE_N-1:0][DOUBLE_W-1:0]  result
);

   localparam int unsigned SettleW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

   state_iter            state_q, state_d;
   double [SIZE_N-1:0]   cur_vec_q, cur_vec_d;
   double [SIZE_N-1:0]   nxt_vec_q, nxt_vec_d;
   logic [IterW-1:0]     iter_cnt_q, iter_cnt_d;
   logic [SettleW-1:0]   settle_cnt_q, settle_cnt_d;
   logic                 done_q, done_d;
   logic                 conv_q, conv_d;

   always_comb begin
      state_d      = state_q;
      cur_vec_d    = cur_vec_q;
      nxt_vec_d    = nxt_vec_q;
      iter_cnt_d   = iter_cnt_q;
      settle_cnt_d = settle_cnt_q;
      done_d       = done_q;
      conv_d       = conv_q;
      unique case (state_q)
         IDLE_IT, DONE_IT: begin
            if (start) begin
               cur_vec_d  = init_vector;
               iter_cnt_d = '0;
               done_d     = 1'b0;
               conv_d     = 1'b0;
               state_d    = CLEAR_IT;
            end
         end
         CLEAR_IT:      state_d = LAUNCH_UPD_IT;
         LAUNCH_UPD_IT: state_d = WAIT_UPD_IT;
         WAIT_UPD_IT: begin
            if (upd_f) begin
               nxt_vec_d = upd_result;
               state_d   = LAUNCH_CV_IT;
            end
         end
         LAUNCH_CV_IT:  state_d = WAIT_CV_IT;
         WAIT_CV_IT: begin
            if (cv_f) begin
               settle_cnt_d = SettleW'(SETTLE);
               state_d      = SETTLE_IT;
            end
         end
         SETTLE_IT: begin
            // Exit while the count is 1 or 0 so this state lasts max(SETTLE,1) cycles.
            if (settle_cnt_q != '0) settle_cnt_d = settle_cnt_q - 1'b1;
            if (settle_cnt_q <= SettleW'(1)) state_d = DECIDE_IT;
         end
         DECIDE_IT: begin
            cur_vec_d = nxt_vec_q;
            if (iter_cnt_q < IterW'(MAX_ITER)) iter_cnt_d = iter_cnt_q + 1'b1;
            if (cv_converged) begin
               conv_d  = 1'b1;
               done_d  = 1'b1;
               state_d = DONE_IT;
            end else if (iter_cnt_q >= IterW'(MAX_ITER - 1)) begin
               conv_d  = 1'b0;
               done_d  = 1'b1;
               state_d = DONE_IT;
            end else begin
               state_d = CLEAR_IT;
            end
         end
         default: state_d = IDLE_IT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE_IT;
         cur_vec_q    <= '0;
         nxt_vec_q    <= '0;
         iter_cnt_q   <= '0;
         settle_cnt_q <= '0;
         done_q       <= 1'b0;
         conv_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cur_vec_q    <= cur_vec_d;
         nxt_vec_q    <= nxt_vec_d;
         iter_cnt_q   <= iter_cnt_d;
         settle_cnt_q <= settle_cnt_d;
         done_q       <= done_d;
         conv_q       <= conv_d;
      end
   end

   // Engines latch their done flag, so they are held cleared throughout reset.
   assign upd_clr        = !rst || (state_q == CLEAR_IT);
   assign cv_clr         = upd_clr;
   assign upd_start      = rst && (state_q == LAUNCH_UPD_IT);
   assign cv_start       = rst && (state_q == LAUNCH_CV_IT);
   assign busy           = (state_q != IDLE_IT) && (state_q != DONE_IT);
   assign done           = done_q;
   assign converged      = conv_q;
   assign iterations     = iter_cnt_q;
   assign upd_vector     = cur_vec_q;
   assign cv_vector      = cur_vec_q;
   assign cv_next_vector = nxt_vec_q;
   assign result         = cur_vec_q;

endmodule
